// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: moves words from four input FIFOs to four output FIFOs through one registered pop->push pipeline.
// Define ARB_RR_EN for round-robin search; otherwise fixed priority P0>P1>P2>P3.
module rr_fifo_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       in_empty,
    input  logic [7:0]       in_dest,
    input  logic [3:0]       out_afull,
    output logic [3:0]       pop,
    output logic [1:0]       select,
    output logic [3:0]       push,
    output logic [1:0]       dest_sel,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);
    typedef enum logic [1:0] {IDLE, ARB, DRAIN} state_t;
    state_t     state, state_nx;
    logic [1:0] start, gnt_idx, tag;
    logic [3:0] elig, pop_nx, push_nx;
    logic       any, gnt;

`ifdef ARB_RR_EN
    logic [1:0] rr_ptr;
    always_ff @(posedge clk or negedge reset)
        if (!reset) rr_ptr <= 2'd0;
        else if (gnt) rr_ptr <= gnt_idx + 2'd1;
    assign start = rr_ptr;
`else
    assign start = 2'd0;
`endif

    // a FIFO popped last cycle still shows a stale empty flag, so it sits out one cycle
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++)
            elig[i] = !in_empty[i] && !out_afull[in_dest[2*i +: 2]] && !pop[i];
    end

    // walk the search order backwards so the earliest eligible input wins
    always_comb begin
        any = 1'b0;
        gnt_idx = start;
        for (int o = 3; o >= 0; o--)
            if (elig[start + 2'(o)]) begin
                any = 1'b1;
                gnt_idx = start + 2'(o);
            end
    end

    assign gnt     = any && state == ARB && enable;
    assign pop_nx  = gnt ? 4'b0001 << gnt_idx : 4'b0000;
    assign push_nx = |pop ? 4'b0001 << tag : 4'b0000;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = enable ? ARB : IDLE;
            ARB:     state_nx = enable ? ARB : DRAIN;
            DRAIN:   state_nx = |pop ? DRAIN : (enable ? ARB : IDLE);
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            pop      <= '0;
            select   <= '0;
            tag      <= '0;
            push     <= '0;
            dest_sel <= '0;
            busy     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            state <= state_nx;
            pop   <= pop_nx;
            push  <= push_nx;
            busy  <= |pop_nx || |push_nx;
            if (gnt) begin
                select <= gnt_idx;
                tag    <= in_dest[2*gnt_idx +: 2];
            end
            if (|pop) dest_sel <= tag;
            if (|push) xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
endmodule

// File: doc/rr_fifo_arbiter.md
# rr_fifo_arbiter

Round-robin arbiter that moves words from four input FIFOs (P0–P3) to four output FIFOs (F0–F3) through a shared 4:1 mux / 1:4 demux datapath. Each input FIFO presents a 2-bit destination tag with its head word. The block grants at most one input per cycle, never pops an empty FIFO, never pushes into an almost-full output, and registers the pop→push pipeline. It sits between the input FIFO bank and the output FIFO bank and replaces fixed-priority pop/push control.

## Interface
- CNT_W, 16, width of the transfer counter `xfer_cnt`
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- enable  in  1  1 = arbitration allowed; 0 = stop granting and drain
- in_empty  in  4  empty flag of input FIFO i (bit i)
- in_dest  in  8  destination tag of the head word of input i, bits [2i+1:2i]
- out_afull  in  4  almost-full flag of output FIFO j (bit j)
- pop  out  4  one-hot pop to input FIFO i
- select  out  2  input-mux select, valid in the pop cycle
- push  out  4  one-hot push to output FIFO j
- dest_sel  out  2  output-demux select, valid in the push cycle
- busy  out  1  1 while a pop or push is outstanding
- xfer_cnt  out  CNT_W  completed-push counter, wraps modulo 2^CNT_W

## Operation
- Input i is eligible when `in_empty[i]==0`, `out_afull[in_dest[i]]==0`, and `pop[i]==0` at that clock edge. A FIFO popped in the previous cycle has a stale empty flag, so back-to-back grants to the same input are forbidden.
- Round-robin pointer `rr_ptr` (2 bits, reset 0). The search order is rr_ptr, rr_ptr+1, … mod 4. The first eligible input is granted. After a grant to input k, rr_ptr becomes k+1 mod 4. With no grant, rr_ptr is held.
- Grant at edge N: pop[k]=1 and select=k, both valid in cycle N. The tag in_dest[k] is latched into the pipeline register.
- Edge N+1: push[tag]=1 and dest_sel=tag, valid for one cycle. xfer_cnt increments at the edge that ends the push cycle.
- FSM with states IDLE, ARB, and DRAIN:
  - IDLE: pop=0 and push=0. Moves to ARB when enable=1.
  - ARB: grants per the rules above. When enable=0, moves to DRAIN.
  - DRAIN: no new grants; any pending push completes. Moves to IDLE when no push is pending. If enable returns to 1 while in DRAIN, moves to ARB once the pending push is done.
- busy = (pop != 0) | (push != 0).
- Simultaneous events:
  - Several eligible inputs: only the first one in rr order is granted.
  - A new grant and the previous word's push occur in the same cycle: this is legal and gives full throughput.
  - Two consecutive words may target the same output.
- Downstream contract: out_afull must assert with at least 3 free entries. This covers one push in flight plus one grant made on a stale flag.

## Timing
- Reset (async, reset=0) sets pop=0, push=0, select=0, dest_sel=0, busy=0, xfer_cnt=0, rr_ptr=0, and state=IDLE.
- Reset asserted mid-transfer drops any pending push; the word is lost. That is acceptable, because the FIFOs are reset together with this block.
- Release of reset is synchronous to the first rising clk edge at which reset=1.
- All outputs are registered; there is no combinational input→output path.
- Latency: 1 cycle from an eligible input to pop, and 2 cycles from an eligible input to push.
- Peak throughput is 1 word per cycle with at least 2 inputs active. A single active input gets 1 word per 2 cycles.

## Configuration
- ARB_RR_EN defined: round-robin as described.
- ARB_RR_EN undefined: fixed priority P0>P1>P2>P3. rr_ptr is removed and the search always starts at 0. The eligibility rules, including the no-back-to-back rule, are unchanged.

## Test plan
- Reset then idle: reset=0 for 3 cycles with all inputs non-empty → pop=0, push=0, xfer_cnt=0. After release with enable=1, the first pop is 4'b0001 one edge later.
- All four inputs non-empty with dest=i, no afull, ARB_RR_EN defined → pop sequence 0001, 0010, 0100, 1000, 0001…; push follows 1 cycle later with the same one-hot; xfer_cnt=8 after 8 pushes.
- Only P2 non-empty with dest=3 → pop=0100 on alternate cycles only; push=1000 one cycle after each pop.
- P0 and P1 both with dest=1, out_afull[1]=1 → no pop. Clear out_afull[1] → grant resumes with P0, then P1.
- enable dropped in the cycle of a grant → that push still occurs next cycle, then busy=0 and no further pops. Re-raising enable resumes from the stored rr_ptr.
- Without ARB_RR_EN, all inputs non-empty → pop alternates 0001, 0010, 0001, 0010; P2 and P3 are never granted.
